// File: rtl/mem_stage.sv
// mem_stage: EX/MEM pipeline register plus a req/ack data-memory access.
// A captured load or store that is word-aligned raises a registered request
// and holds it until the memory acks it or the wait counter expires. EX is
// stalled for that time. Every retired instruction produces a one-cycle
// write-back pulse with its destination, data and branch decision.
module mem_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] out,
  input  logic        zero,
  input  logic [31:0] regOut2,
  input  logic [31:0] instructionMEMREAD,
  input  logic        regdst,
  input  logic        WBData,
  input  logic        branch,
  input  logic        regWrite,
  input  logic        dataMemWrite,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_regWrite,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        pc_src,
  output logic        mem_err
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  typedef enum logic {IDLE, ACCESS} stateT;

  stateT         state;
  stateT         nextState;
  logic [CW-1:0] waitCnt;

  // Fields of the instruction held while its memory access is in flight
  logic          capStore;
  logic          capRegWrite;
  logic          capBranchTaken;
  logic [4:0]    capDest;

  // Decoded view of the incoming EX outputs and of the access in flight
  logic          isStore;
  logic          isMem;
  logic          aligned;
  logic [4:0]    dest;
  logic          startAccess;
  logic          accessDone;
  logic          accessTimeout;

  // Only the register-specifier fields of the instruction word are consumed
  logic          unusedInstr;
  assign unusedInstr = ^{instructionMEMREAD[31:21], instructionMEMREAD[10:0]};

  // Classify the incoming instruction and detect how the current access ends
  always_comb begin
    isStore       = dataMemWrite;
    isMem         = dataMemWrite | WBData;
    aligned       = (out[1:0] == 2'b00);
    dest          = regdst ? instructionMEMREAD[15:11] : instructionMEMREAD[20:16];
    startAccess   = (state == IDLE) && ex_valid && isMem && aligned;
    accessDone    = (state == ACCESS) && dmem_ack;
    accessTimeout = (state == ACCESS) && !dmem_ack && (waitCnt == LAST_WAIT);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state: enter ACCESS on an aligned load/store, leave on ack or timeout
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startAccess) nextState = ACCESS;
      ACCESS:  if (accessDone || accessTimeout) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs decoded straight from the state
  always_comb begin
    stall = (state == ACCESS);
  end

  // Pipeline register, memory request and write-back result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt        <= '0;
      capStore       <= 1'b0;
      capRegWrite    <= 1'b0;
      capBranchTaken <= 1'b0;
      capDest        <= '0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      wb_valid       <= 1'b0;
      wb_regWrite    <= 1'b0;
      wb_dest        <= '0;
      wb_data        <= '0;
      pc_src         <= 1'b0;
      mem_err        <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      pc_src   <= 1'b0;
      mem_err  <= 1'b0;
      if (state == IDLE) begin
        if (startAccess) begin
          waitCnt        <= '0;
          capStore       <= isStore;
          capRegWrite    <= regWrite;
          capBranchTaken <= branch & zero;
          capDest        <= dest;
          dmem_req       <= 1'b1;
          dmem_we        <= isStore;
          dmem_addr      <= out;
          dmem_wdata     <= regOut2;
        end else if (ex_valid) begin
          wb_valid    <= 1'b1;
          wb_dest     <= dest;
          wb_data     <= out;
          wb_regWrite <= regWrite && (dest != 5'd0) && !isMem;
          mem_err     <= isMem;
          pc_src      <= branch & zero;
        end
      end else begin
        if (accessDone) begin
          dmem_req    <= 1'b0;
          wb_valid    <= 1'b1;
          wb_dest     <= capDest;
          wb_data     <= capStore ? dmem_addr : dmem_rdata;
          wb_regWrite <= capRegWrite && (capDest != 5'd0);
          pc_src      <= capBranchTaken;
        end else if (accessTimeout) begin
          dmem_req    <= 1'b0;
          wb_valid    <= 1'b1;
          wb_dest     <= capDest;
          wb_data     <= dmem_addr;
          wb_regWrite <= 1'b0;
          mem_err     <= 1'b1;
          pc_src      <= capBranchTaken;
        end else begin
          waitCnt <= waitCnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a
// transaction-level model of the stage's retirement rules.
module tb_mem_stage;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] out;
  logic        zero;
  logic [31:0] regOut2;
  logic [31:0] instructionMEMREAD;
  logic        regdst;
  logic        WBData;
  logic        branch;
  logic        regWrite;
  logic        dataMemWrite;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic        wb_regWrite;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        pc_src;
  logic        mem_err;

  int checks = 0;
  int errors = 0;
  logic [4:0] lastDest = 5'd0;

  typedef struct packed {
    logic [31:0] aluOut;
    logic        zeroFlag;
    logic [31:0] storeData;
    logic [31:0] instr;
    logic        selRd;
    logic        isLoadFlag;
    logic        isBranch;
    logic        writesReg;
    logic        isStoreFlag;
  } instT;

  mem_stage #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .out(out), .zero(zero),
    .regOut2(regOut2), .instructionMEMREAD(instructionMEMREAD),
    .regdst(regdst), .WBData(WBData), .branch(branch), .regWrite(regWrite),
    .dataMemWrite(dataMemWrite), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid),
    .wb_regWrite(wb_regWrite), .wb_dest(wb_dest), .wb_data(wb_data),
    .pc_src(pc_src), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] instrRd(input logic [4:0] rd);
    logic [31:0] w;
    w = '0;
    w[15:11] = rd;
    return w;
  endfunction

  function automatic logic [31:0] instrRt(input logic [4:0] rt);
    logic [31:0] w;
    w = '0;
    w[20:16] = rt;
    return w;
  endfunction

  function automatic instT mkInst(input logic [31:0] a, input logic z,
                                  input logic [31:0] sd, input logic [31:0] ins,
                                  input logic rdSel, input logic ld,
                                  input logic br, input logic rw, input logic st);
    instT t;
    t.aluOut = a; t.zeroFlag = z; t.storeData = sd; t.instr = ins;
    t.selRd = rdSel; t.isLoadFlag = ld; t.isBranch = br;
    t.writesReg = rw; t.isStoreFlag = st;
    return t;
  endfunction

  function automatic instT randInst();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(3) != 0) a[1:0] = 2'b00;
    return mkInst(a, 1'($urandom_range(1)), $urandom, $urandom,
                  1'($urandom_range(1)), 1'($urandom_range(2) == 0),
                  1'($urandom_range(1)), 1'($urandom_range(3) != 0),
                  1'($urandom_range(3) == 0));
  endfunction

  task automatic driveFields(input instT t);
    out                = t.aluOut;
    zero               = t.zeroFlag;
    regOut2            = t.storeData;
    instructionMEMREAD = t.instr;
    regdst             = t.selRd;
    WBData             = t.isLoadFlag;
    branch             = t.isBranch;
    regWrite           = t.writesReg;
    dataMemWrite       = t.isStoreFlag;
  endtask

  // Issue one instruction, play the memory side with the given ack delay
  // (a delay beyond MAXW means the memory never answers), and check the
  // stall window and the retirement against the model's predictions.
  task automatic applyStimulus(input instT t, input int ackDelay,
                               input logic [31:0] rdata);
    logic [4:0]  expDest;
    logic [31:0] expData;
    logic        storeOp, memOp, alignedOp, expErr, expWe, expPc;
    int          accessCycles;

    expDest   = t.selRd ? t.instr[15:11] : t.instr[20:16];
    storeOp   = t.isStoreFlag;
    memOp     = t.isStoreFlag || t.isLoadFlag;
    alignedOp = (t.aluOut % 4) == 0;
    expPc     = t.isBranch && t.zeroFlag;
    expWe     = 1'b0;
    if (!memOp) begin
      accessCycles = 0; expErr = 1'b0; expData = t.aluOut;
    end else if (!alignedOp) begin
      accessCycles = 0; expErr = 1'b1; expData = t.aluOut;
    end else if (ackDelay <= MAXW) begin
      accessCycles = ackDelay; expErr = 1'b0;
      expData = storeOp ? t.aluOut : rdata;
    end else begin
      accessCycles = MAXW; expErr = 1'b1; expData = t.aluOut;
    end
    if (!expErr) expWe = t.writesReg && (expDest != 5'd0);

    driveFields(t);
    ex_valid = 1'b1;
    dmem_ack = (accessCycles == 0) ? 1'($urandom_range(1)) : 1'b0;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    dmem_ack = 1'b0;

    for (int c = 1; c <= accessCycles; c++) begin
      @(negedge clk);
      checkOutput("stall_access", 32'(stall), 32'd1);
      checkOutput("req_access", 32'(dmem_req), 32'd1);
      checkOutput("we_access", 32'(dmem_we), 32'(storeOp));
      checkOutput("addr_access", dmem_addr, t.aluOut);
      if (storeOp) checkOutput("wdata_access", dmem_wdata, t.storeData);
      checkOutput("wbvalid_access", 32'(wb_valid), 32'd0);
      driveFields(randInst());
      ex_valid = 1'($urandom_range(1));
      if (c == ackDelay) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
      end else begin
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
      end
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      ex_valid = 1'b0;
    end

    @(negedge clk);
    checkOutput("wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("stall_wb", 32'(stall), 32'd0);
    checkOutput("req_wb", 32'(dmem_req), 32'd0);
    checkOutput("mem_err", 32'(mem_err), 32'(expErr));
    checkOutput("wb_regWrite", 32'(wb_regWrite), 32'(expWe));
    checkOutput("wb_dest", 32'(wb_dest), 32'(expDest));
    if (!expErr) checkOutput("wb_data", wb_data, expData);
    checkOutput("pc_src", 32'(pc_src), 32'(expPc));
    lastDest = expDest;
  endtask

  // One cycle with nothing issued: pulses must be low, buses must hold
  task automatic idleCycle();
    ex_valid = 1'b0;
    dmem_ack = 1'($urandom_range(1));
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    checkOutput("idle_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("idle_mem_err", 32'(mem_err), 32'd0);
    checkOutput("idle_pc_src", 32'(pc_src), 32'd0);
    checkOutput("idle_req", 32'(dmem_req), 32'd0);
    checkOutput("idle_dest_hold", 32'(wb_dest), 32'(lastDest));
  endtask

  // Reset asserted two cycles into an access that the memory never answers
  task automatic resetMidAccess();
    driveFields(mkInst(32'h400, 1'b0, 32'h0, instrRt(5'd8), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    ex_valid = 1'b1;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_pre_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_req_drop", 32'(dmem_req), 32'd0);
    checkOutput("rst_stall_drop", 32'(stall), 32'd0);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    lastDest = 5'd0;
    for (int i = 0; i < 2; i++) begin
      dmem_ack   = 1'b1;
      dmem_rdata = $urandom;
      @(posedge clk);
      @(negedge clk);
      checkOutput("late_ack_wb_valid", 32'(wb_valid), 32'd0);
      checkOutput("late_ack_req", 32'(dmem_req), 32'd0);
      checkOutput("late_ack_stall", 32'(stall), 32'd0);
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    driveFields(mkInst(0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_req", 32'(dmem_req), 32'd0);
    checkOutput("reset_we", 32'(dmem_we), 32'd0);
    checkOutput("reset_addr", dmem_addr, 32'd0);
    checkOutput("reset_wdata", dmem_wdata, 32'd0);
    checkOutput("reset_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("reset_wb_regWrite", 32'(wb_regWrite), 32'd0);
    checkOutput("reset_wb_dest", 32'(wb_dest), 32'd0);
    checkOutput("reset_wb_data", wb_data, 32'd0);
    checkOutput("reset_pc_src", 32'(pc_src), 32'd0);
    checkOutput("reset_mem_err", 32'(mem_err), 32'd0);

    // Back-to-back ALU ops
    applyStimulus(mkInst(32'h11, 0, 0, instrRd(5'd5), 1, 0, 0, 1, 0), 0, 0);
    applyStimulus(mkInst(32'h22, 0, 0, instrRd(5'd6), 1, 0, 0, 1, 0), 0, 0);
    applyStimulus(mkInst(32'h33, 0, 0, instrRd(5'd7), 1, 0, 0, 1, 0), 0, 0);
    idleCycle();
    // Load with a three-cycle wait
    applyStimulus(mkInst(32'h100, 0, 0, instrRt(5'd9), 0, 1, 0, 1, 0), 3, 32'hDEADBEEF);
    // Aligned store, misaligned store, write to r0
    applyStimulus(mkInst(32'h200, 0, 32'hCAFEF00D, instrRt(5'd3), 0, 0, 0, 0, 1), 1, 0);
    applyStimulus(mkInst(32'h202, 0, 32'h12345678, instrRt(5'd3), 0, 0, 0, 1, 1), 1, 0);
    applyStimulus(mkInst(32'h55, 0, 0, instrRd(5'd0), 1, 0, 0, 1, 0), 0, 0);
    // Timeout followed by a normal ALU op
    applyStimulus(mkInst(32'h300, 0, 0, instrRt(5'd4), 0, 1, 0, 1, 0), 100, 0);
    applyStimulus(mkInst(32'h77, 0, 0, instrRd(5'd12), 1, 0, 0, 1, 0), 0, 0);
    // Ack arriving on the last allowed cycle completes the access
    applyStimulus(mkInst(32'h500, 0, 0, instrRt(5'd10), 0, 1, 0, 1, 0), MAXW, 32'hA5A5_0F0F);
    // Branch taken and not taken
    applyStimulus(mkInst(32'h0, 1, 0, instrRt(5'd0), 0, 0, 1, 0, 0), 0, 0);
    applyStimulus(mkInst(32'h4, 0, 0, instrRt(5'd0), 0, 0, 1, 0, 0), 0, 0);
    idleCycle();
    // Reset during an access, then recovery
    resetMidAccess();
    applyStimulus(mkInst(32'h99, 0, 0, instrRd(5'd2), 1, 0, 0, 1, 0), 0, 0);

    // Randomized instruction stream with random memory latency
    for (int n = 0; n < 300; n++) begin
      applyStimulus(randInst(), $urandom_range(1, MAXW + 2), $urandom);
      if ($urandom_range(3) == 0) idleCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
